// File: rtl/dw_mac_array.sv
// dw_mac_array: depthwise convolution MAC stage.
// Takes one POY x POX pixel slice per dwpe_ena cycle and multiplies it by the
// weight of the current kernel tap. After KSIZE*KSIZE taps it adds the bias,
// shifts right arithmetically by SHIFT, applies ReLU / CLIP and saturates to OW.
// The result block is held in an output register.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   dwpe_ena, dwpixel_array  one tap of pixels per high cycle
//   blkend                   block end: resets the tap counter, drops a partial window
//   w_we, w_addr, w_data     weight write (tap index, value)
//   b_we, b_data             bias write
//   out_valid, out_ready     result handshake
//   out_data                 result block
//   tap_busy                 window in progress (tap counter nonzero)
//   ovf                      sticky: a result was dropped because the output was held
//   werr                     one-cycle pulse: a weight or bias write was rejected
//
// Handshake: a block moves only on an edge where out_valid=1 and out_ready=1.
// While out_valid=1 and out_ready=0, out_data holds steady. A new result that
// arrives in that state is dropped and ovf is set. An accept and a new result
// on the same edge load the new result, and out_valid stays high.
module dw_mac_array #(
  parameter int DW    = 32,
  parameter int WW    = 16,
  parameter int AW    = 64,
  parameter int OW    = 32,
  parameter int POY   = 3,
  parameter int POX   = 16,
  parameter int KSIZE = 3,
  parameter int SHIFT = 16,
  parameter int RELU  = 1,
  parameter int CLIP  = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   dwpe_ena,
  input  logic                                   blkend,
  input  logic [POY-1:0][POX-1:0][DW-1:0]        dwpixel_array,
  input  logic                                   w_we,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]         w_addr,
  input  logic [WW-1:0]                          w_data,
  input  logic                                   b_we,
  input  logic [AW-1:0]                          b_data,
  input  logic                                   out_ready,
  output logic                                   out_valid,
  output logic [POY-1:0][POX-1:0][OW-1:0]        out_data,
  output logic                                   tap_busy,
  output logic                                   ovf,
  output logic                                   werr
);

  localparam int NT = KSIZE * KSIZE;
  localparam int TW = $clog2(NT);
  localparam logic [TW-1:0]        LAST_TAP = TW'(NT - 1);
  localparam logic signed [AW-1:0] CLIP_V   = AW'(CLIP);
  localparam logic signed [AW-1:0] OMAX     = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN     = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [TW-1:0]                   tc;
  logic [NT-1:0][WW-1:0]           wreg;
  logic signed [AW-1:0]            bias;
  logic                            s1_valid, s1_first, s1_last;
  logic [POY-1:0][POX-1:0][AW-1:0] s1_prod, prod_n, acc;
  logic                            s2_done;
  logic [POY-1:0][POX-1:0][OW-1:0] res_n;
  logic                            last_now, take_tap, s1_use, wr_ok, w_bad;

  // If blkend arrives on the same edge as the final tap, the window still
  // completes. So the final tap and the tap already in stage 1 both survive.
  assign last_now = dwpe_ena && (tc == LAST_TAP);
  assign take_tap = dwpe_ena && (!blkend || (tc == LAST_TAP));
  assign s1_use   = s1_valid && (s1_last || !blkend || last_now);
  // Weights may change only between windows, once the pipeline has drained
  // through the accumulate stage.
  assign wr_ok    = (tc == '0) && !s1_valid && !s2_done;
  assign w_bad    = w_we && (w_addr > LAST_TAP);
  assign tap_busy = (tc != '0);

  always_comb begin
    prod_n = '0;
    for (int y = 0; y < POY; y++) begin
      for (int x = 0; x < POX; x++) begin
        prod_n[y][x] = AW'($signed(dwpixel_array[y][x])) * AW'($signed(wreg[tc]));
      end
    end
  end

  always_comb begin : post_proc
    logic signed [AW-1:0] sum_v;
    logic signed [AW-1:0] r_v;
    sum_v = '0;
    r_v   = '0;
    res_n = '0;
    for (int y = 0; y < POY; y++) begin
      for (int x = 0; x < POX; x++) begin
        sum_v = $signed(acc[y][x]) + bias;
        r_v   = sum_v >>> SHIFT;
        if (RELU != 0 && r_v[AW-1]) r_v = '0;
        if (CLIP != 0 && r_v > CLIP_V) r_v = CLIP_V;
        if (r_v > OMAX) r_v = OMAX;
        else if (r_v < OMIN) r_v = OMIN;
        res_n[y][x] = r_v[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc        <= '0;
      wreg      <= '0;
      bias      <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_prod   <= '0;
      acc       <= '0;
      s2_done   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
      werr      <= 1'b0;
    end else begin
      // Tap counter
      if (blkend) tc <= '0;
      else if (dwpe_ena) tc <= (tc == LAST_TAP) ? '0 : tc + TW'(1);

      // Stage 1: multiply
      s1_valid <= take_tap;
      if (dwpe_ena) begin
        s1_prod  <= prod_n;
        s1_first <= (tc == '0);
        s1_last  <= (tc == LAST_TAP);
      end

      // Stage 2: accumulate. The first tap overwrites, so a window dropped
      // by blkend leaves nothing behind that needs clearing.
      if (s1_use) begin
        for (int y = 0; y < POY; y++) begin
          for (int x = 0; x < POX; x++) begin
            acc[y][x] <= s1_first ? s1_prod[y][x] : acc[y][x] + s1_prod[y][x];
          end
        end
      end
      s2_done <= s1_use && s1_last;

      // Weight / bias writes
      werr <= ((w_we || b_we) && !wr_ok) || w_bad;
      if (wr_ok) begin
        if (w_we && !w_bad) wreg[w_addr] <= w_data;
        if (b_we) bias <= b_data;
      end

      // Stage 3: post-process into the output register
      if (s2_done) begin
        if (!out_valid || out_ready) begin
          out_data  <= res_n;
          out_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dw_mac_array.sv
module tb_dw_mac_array;

  localparam int DW = 32, WW = 16, AW = 64, OW = 32, POY = 3, POX = 16;
  localparam int NT = 9, NB = POY * POX, ND = 4;

  logic              clk = 1'b0;
  logic              rst, dwpe_ena, blkend, w_we, b_we, out_ready;
  logic [NB*DW-1:0]  pix_flat;
  logic [3:0]        w_addr;
  logic [WW-1:0]     w_data;
  logic [AW-1:0]     b_data;
  logic              ov[ND], tb_busy[ND], ovf_s[ND], werr_s[ND];
  logic [NB*OW-1:0]  od[ND];

  int checks = 0;
  int failures = 0;

  // Reference model state
  longint w_m[NT];
  longint b_m;
  longint pix_m[NT][NB];
  logic [NB*AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Four copies share the stimulus: dut0 SHIFT0/ReLU, dut1 SHIFT0/no ReLU,
  // dut2 SHIFT0/ReLU/CLIP6, dut3 default SHIFT16/ReLU.
  for (genvar g = 0; g < ND; g++) begin : g_dut
    dw_mac_array #(
      .DW(DW), .WW(WW), .AW(AW), .OW(OW), .POY(POY), .POX(POX), .KSIZE(3),
      .SHIFT((g == 3) ? 16 : 0), .RELU((g == 1) ? 0 : 1), .CLIP((g == 2) ? 6 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .dwpe_ena(dwpe_ena), .blkend(blkend),
      .dwpixel_array(pix_flat), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .b_we(b_we), .b_data(b_data), .out_ready(out_ready),
      .out_valid(ov[g]), .out_data(od[g]), .tap_busy(tb_busy[g]),
      .ovf(ovf_s[g]), .werr(werr_s[g])
    );
  end

  function automatic int p_shift(int g); return (g == 3) ? 16 : 0; endfunction
  function automatic int p_relu(int g);  return (g == 1) ? 0 : 1;  endfunction
  function automatic int p_clip(int g);  return (g == 2) ? 6 : 0;  endfunction

  function automatic logic [OW-1:0] finalize(longint s, int sh, int relu, int clip);
    longint r;
    r = s >>> sh;
    if (relu != 0 && r < 0) r = 0;
    if (clip != 0 && r > longint'(clip)) r = longint'(clip);
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r[OW-1:0];
  endfunction

  // Full window sum per pixel: bias + sum over taps of pixel*weight
  function automatic logic [NB*AW-1:0] window_sums();
    logic [NB*AW-1:0] v;
    longint s;
    v = '0;
    for (int i = 0; i < NB; i++) begin
      s = b_m;
      for (int t = 0; t < NT; t++) s += pix_m[t][i] * w_m[t];
      v[i*AW +: AW] = s;
    end
    return v;
  endfunction

  function automatic logic [NB*OW-1:0] exp_block(logic [NB*AW-1:0] s, int g);
    logic [NB*OW-1:0] e;
    longint si;
    e = '0;
    for (int i = 0; i < NB; i++) begin
      si = longint'($signed(s[i*AW +: AW]));
      e[i*OW +: OW] = finalize(si, p_shift(g), p_relu(g), p_clip(g));
    end
    return e;
  endfunction

  function automatic int first_diff(logic [NB*OW-1:0] a, logic [NB*OW-1:0] b);
    for (int i = 0; i < NB; i++) if (a[i*OW +: OW] !== b[i*OW +: OW]) return i;
    return 0;
  endfunction

  // ---------------- stimulus drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(int t);
    longint v;
    for (int i = 0; i < NB; i++) begin
      v = pix_m[t][i];
      pix_flat[i*DW +: DW] = v[DW-1:0];
    end
  endtask

  task automatic load_uniform(longint val);
    for (int t = 0; t < NT; t++) for (int i = 0; i < NB; i++) pix_m[t][i] = val;
  endtask

  task automatic drive_tap(int t, bit be);
    set_pix(t);
    dwpe_ena = 1'b1;
    blkend = be;
    tick();
    dwpe_ena = 1'b0;
    blkend = 1'b0;
  endtask

  task automatic send_window(int gap, bit be_last);
    for (int t = 0; t < NT; t++) begin
      if (t > 0) for (int k = 0; k < gap; k++) tick();
      drive_tap(t, be_last && (t == NT - 1));
    end
    exp_q.push_back(window_sums());
  endtask

  task automatic write_params();
    longint lv;
    for (int t = 0; t < NT; t++) begin
      lv = w_m[t];
      w_we = 1'b1;
      w_addr = 4'(t);
      w_data = lv[WW-1:0];
      b_we = (t == 0);
      b_data = b_m;
      tick();
    end
    w_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic set_weights(longint v);
    for (int t = 0; t < NT; t++) w_m[t] = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dwpe_ena = (c % 2 == 0);
      tick();
      for (int g = 0; g < ND; g++) begin
        checks++;
        if (ov[g] !== 1'b0 || od[g] !== '0 || ovf_s[g] !== 1'b0 || tb_busy[g] !== 1'b0 || werr_s[g] !== 1'b0) begin
          failures++;
          $display("FAIL reset dut%0d cyc%0d got valid=%b ovf=%b busy=%b werr=%b data0=%h want all 0",
                   g, c, ov[g], ovf_s[g], tb_busy[g], werr_s[g], od[g][OW-1:0]);
        end
      end
    end
    rst = 1'b0;
    dwpe_ena = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [NB*AW-1:0] s;
    logic [NB*OW-1:0] e;
    int n, i;
    set_weights(1); b_m = 0;
    write_params();
    load_uniform(2);
    send_window(0, 1'b0);
    n = 0;
    while (ov[0] !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (ov[0] !== 1'b1 || n != 2) begin
      failures++;
      $display("FAIL basic_latency got valid=%b after %0d cycles want 1 after 2", ov[0], n);
    end
    s = exp_q.pop_front();
    for (int g = 0; g < ND; g++) begin
      e = exp_block(s, g);
      checks++;
      if (od[g] !== e) begin
        failures++; i = first_diff(od[g], e);
        $display("FAIL basic_data dut%0d elem%0d got=%0d want=%0d", g, i, $signed(od[g][i*OW +: OW]), $signed(e[i*OW +: OW]));
      end
    end
    checks++;
    if (od[0][OW-1:0] !== 32'd18) begin
      failures++; $display("FAIL basic_literal got=%0d want=18", $signed(od[0][OW-1:0]));
    end
    e = exp_block(s, 0);
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== e) begin
      failures++; $display("FAIL basic_hold got valid=%b data0=%0d want valid=1 data0=18", ov[0], $signed(od[0][OW-1:0]));
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (ov[0] !== 1'b0) begin failures++; $display("FAIL basic_accept got valid=%b want 0", ov[0]); end
  endtask

  task automatic test_gap_bias();
    logic [NB*AW-1:0] s;
    logic [NB*OW-1:0] e;
    int n, i;
    for (int t = 0; t < NT; t++) w_m[t] = t + 1;
    b_m = 100;
    write_params();
    load_uniform(1);
    for (int t = 0; t < NT; t++) begin
      if (t > 0) for (int k = 0; k < 2; k++) begin
        tick();
        checks++;
        if (tb_busy[0] !== 1'b1) begin failures++; $display("FAIL gap_busy_idle tap%0d got=%b want=1", t, tb_busy[0]); end
      end
      drive_tap(t, 1'b0);
      checks++;
      if (tb_busy[0] !== (t != NT - 1)) begin
        failures++; $display("FAIL gap_busy_tap tap%0d got=%b want=%b", t, tb_busy[0], (t != NT - 1));
      end
    end
    exp_q.push_back(window_sums());
    n = 0;
    while (ov[0] !== 1'b1 && n < 20) begin tick(); n++; end
    s = exp_q.pop_front();
    for (int g = 0; g < ND; g++) begin
      e = exp_block(s, g);
      checks++;
      if (od[g] !== e || ov[g] !== 1'b1) begin
        failures++; i = first_diff(od[g], e);
        $display("FAIL gap_data dut%0d elem%0d valid=%b got=%0d want=%0d", g, i, ov[g], $signed(od[g][i*OW +: OW]), $signed(e[i*OW +: OW]));
      end
    end
    checks++;
    if (od[0][(NB-1)*OW +: OW] !== 32'd145) begin
      failures++; $display("FAIL gap_literal got=%0d want=145", $signed(od[0][(NB-1)*OW +: OW]));
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_blkend();
    logic [NB*AW-1:0] s;
    logic [NB*OW-1:0] e;
    int n, i, seen;
    set_weights(1); b_m = 0;
    write_params();
    load_uniform(3);
    for (int t = 0; t < 4; t++) drive_tap(t, 1'b0);
    drive_tap(4, 1'b1);  // non-final tap sampled together with blkend
    checks++;
    if (tb_busy[0] !== 1'b0) begin failures++; $display("FAIL blkend_tc got busy=%b want 0", tb_busy[0]); end
    seen = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (ov[0] === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL blkend_abort got %0d valid cycles want 0", seen); end
    send_window(0, 1'b1);  // final tap sampled with blkend still completes
    n = 0;
    while (ov[0] !== 1'b1 && n < 20) begin tick(); n++; end
    s = exp_q.pop_front();
    for (int g = 0; g < ND; g++) begin
      e = exp_block(s, g);
      checks++;
      if (od[g] !== e || ov[g] !== 1'b1) begin
        failures++; i = first_diff(od[g], e);
        $display("FAIL blkend_data dut%0d elem%0d valid=%b got=%0d want=%0d", g, i, ov[g], $signed(od[g][i*OW +: OW]), $signed(e[i*OW +: OW]));
      end
    end
    checks++;
    if (od[0][OW-1:0] !== 32'd27) begin failures++; $display("FAIL blkend_literal got=%0d want=27", $signed(od[0][OW-1:0])); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_clamp();
    logic [NB*AW-1:0] s;
    logic [NB*OW-1:0] e;
    int n, i;
    for (int pass = 0; pass < 2; pass++) begin
      set_weights(pass == 0 ? -1 : 1); b_m = 0;
      write_params();
      load_uniform(5);
      send_window(0, 1'b0);
      n = 0;
      while (ov[0] !== 1'b1 && n < 20) begin tick(); n++; end
      s = exp_q.pop_front();
      for (int g = 0; g < ND; g++) begin
        e = exp_block(s, g);
        checks++;
        if (od[g] !== e || ov[g] !== 1'b1) begin
          failures++; i = first_diff(od[g], e);
          $display("FAIL clamp_data pass%0d dut%0d elem%0d got=%0d want=%0d", pass, g, i, $signed(od[g][i*OW +: OW]), $signed(e[i*OW +: OW]));
        end
      end
      checks++;
      if ($signed(od[0][OW-1:0]) != (pass == 0 ? 0 : 45) || $signed(od[1][OW-1:0]) != (pass == 0 ? -45 : 45)
          || $signed(od[2][OW-1:0]) != (pass == 0 ? 0 : 6)) begin
        failures++;
        $display("FAIL clamp_literal pass%0d got relu=%0d norelu=%0d clip=%0d", pass,
                 $signed(od[0][OW-1:0]), $signed(od[1][OW-1:0]), $signed(od[2][OW-1:0]));
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure_werr();
    logic [NB*AW-1:0] s;
    logic [NB*OW-1:0] e;
    int n, i;
    set_weights(1); b_m = 0;
    write_params();
    out_ready = 1'b0;
    load_uniform(1); send_window(0, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    load_uniform(2); send_window(0, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    void'(exp_q.pop_back());  // second result is dropped
    s = exp_q.pop_front();
    for (int g = 0; g < ND; g++) begin
      e = exp_block(s, g);
      checks++;
      if (od[g] !== e || ov[g] !== 1'b1 || ovf_s[g] !== 1'b1) begin
        failures++; i = first_diff(od[g], e);
        $display("FAIL bp_hold dut%0d elem%0d valid=%b ovf=%b got=%0d want=%0d ovf=1", g, i, ov[g], ovf_s[g], $signed(od[g][i*OW +: OW]), $signed(e[i*OW +: OW]));
      end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || ovf_s[0] !== 1'b1) begin failures++; $display("FAIL bp_sticky got valid=%b ovf=%b want 0 1", ov[0], ovf_s[0]); end

    // Write at tc=3 is rejected
    load_uniform(1);
    for (int t = 0; t < 3; t++) drive_tap(t, 1'b0);
    w_we = 1'b1; w_addr = 4'd0; w_data = 16'd7;
    tick();
    w_we = 1'b0;
    checks++;
    if (werr_s[0] !== 1'b1) begin failures++; $display("FAIL werr_pulse got=%b want=1", werr_s[0]); end
    tick();
    checks++;
    if (werr_s[0] !== 1'b0) begin failures++; $display("FAIL werr_clear got=%b want=0", werr_s[0]); end
    for (int t = 3; t < NT; t++) drive_tap(t, 1'b0);
    exp_q.push_back(window_sums());
    n = 0;
    while (ov[0] !== 1'b1 && n < 20) begin tick(); n++; end
    s = exp_q.pop_front();
    for (int g = 0; g < ND; g++) begin
      e = exp_block(s, g);
      checks++;
      if (od[g] !== e || ov[g] !== 1'b1) begin
        failures++; i = first_diff(od[g], e);
        $display("FAIL werr_weight dut%0d elem%0d got=%0d want=%0d", g, i, $signed(od[g][i*OW +: OW]), $signed(e[i*OW +: OW]));
      end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    // Out-of-range address at idle is rejected; a legal idle write is not
    w_we = 1'b1; w_addr = 4'd9; w_data = 16'd3; tick();
    checks++;
    if (werr_s[0] !== 1'b1) begin failures++; $display("FAIL werr_addr got=%b want=1", werr_s[0]); end
    w_addr = 4'd0; w_data = 16'd1; tick(); w_we = 1'b0;
    checks++;
    if (werr_s[0] !== 1'b0) begin failures++; $display("FAIL werr_ok got=%b want=0", werr_s[0]); end
  endtask

  task automatic test_reset_mid();
    logic [NB*AW-1:0] s;
    logic [NB*OW-1:0] e;
    int n, i;
    load_uniform(4);
    for (int t = 0; t < 5; t++) drive_tap(t, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    set_weights(0); b_m = 0;  // weights and bias clear on reset
    for (int g = 0; g < ND; g++) begin
      checks++;
      if (ov[g] !== 1'b0 || tb_busy[g] !== 1'b0 || ovf_s[g] !== 1'b0) begin
        failures++; $display("FAIL rstmid_state dut%0d got valid=%b busy=%b ovf=%b want 0", g, ov[g], tb_busy[g], ovf_s[g]);
      end
    end
    n = 0;
    for (int c = 0; c < 4; c++) begin tick(); if (ov[0] === 1'b1) n++; end
    checks++;
    if (n != 0) begin failures++; $display("FAIL rstmid_noout got %0d valid cycles want 0", n); end
    send_window(0, 1'b0);
    n = 0;
    while (ov[0] !== 1'b1 && n < 20) begin tick(); n++; end
    s = exp_q.pop_front();
    for (int g = 0; g < ND; g++) begin
      e = exp_block(s, g);
      checks++;
      if (od[g] !== e || ov[g] !== 1'b1) begin
        failures++; i = first_diff(od[g], e);
        $display("FAIL rstmid_data dut%0d elem%0d got=%0d want=%0d", g, i, $signed(od[g][i*OW +: OW]), $signed(e[i*OW +: OW]));
      end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [NB*AW-1:0] s;
    logic [NB*OW-1:0] e;
    int i, k, got;
    got = 0;
    out_ready = 1'b1;
    for (int rep = 0; rep < 3; rep++) begin
      for (int t = 0; t < NT; t++) w_m[t] = longint'($signed(16'($urandom)));
      b_m = longint'($signed($urandom)) * 256;
      write_params();
      for (int win = 0; win < 3; win++) begin
        for (int t = 0; t < NT; t++) for (int j = 0; j < NB; j++) pix_m[t][j] = longint'($signed($urandom));
        for (int t = 0; t < NT + 6; t++) begin
          k = (rep == 0 || t >= NT) ? 0 : $urandom_range(0, 1);
          for (int c = 0; c <= k; c++) begin
            if (c == k && t < NT) begin set_pix(t); dwpe_ena = 1'b1; end
            tick();
            dwpe_ena = 1'b0;
            if (c == k && t == NT - 1) exp_q.push_back(window_sums());
            if (ov[0] === 1'b1) begin
              got++;
              checks++;
              if (exp_q.size() == 0) begin
                failures++; $display("FAIL b2b_unexpected got valid=1 want no result pending");
              end else begin
                s = exp_q.pop_front();
                for (int g = 0; g < ND; g++) begin
                  e = exp_block(s, g);
                  checks++;
                  if (od[g] !== e) begin
                    failures++; i = first_diff(od[g], e);
                    $display("FAIL b2b_data rep%0d dut%0d elem%0d got=%0d want=%0d", rep, g, i, $signed(od[g][i*OW +: OW]), $signed(e[i*OW +: OW]));
                  end
                end
              end
            end
          end
          if (rep == 0 && t == NT - 1) t = NT + 5;  // rep 0: windows strictly back to back
        end
      end
      for (int c = 0; c < 4; c++) begin
        tick();
        if (ov[0] === 1'b1 && exp_q.size() > 0) begin
          got++;
          s = exp_q.pop_front();
          e = exp_block(s, 3);
          checks++;
          if (od[3] !== e) begin
            failures++; i = first_diff(od[3], e);
            $display("FAIL b2b_drain dut3 elem%0d got=%0d want=%0d", i, $signed(od[3][i*OW +: OW]), $signed(e[i*OW +: OW]));
          end
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (got != 9 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_count got=%0d results pending=%0d want 9 and 0", got, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; dwpe_ena = 1'b0; blkend = 1'b0; w_we = 1'b0; b_we = 1'b0;
    out_ready = 1'b0; w_addr = '0; w_data = '0; b_data = '0; pix_flat = '0;
    b_m = 0;
    set_weights(0);
    test_reset();
    test_basic();
    test_gap_bias();
    test_blkend();
    test_clamp();
    test_backpressure_werr();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dw_mac_array.md
Name: dw_mac_array

Overview:
- Depthwise convolution compute stage that sits directly downstream of the data router.
- Consumes one POY×POX pixel slice per dwpe_ena cycle and multiplies it by the current kernel tap weight.
- Accumulates KSIZE×KSIZE taps per output pixel, then adds bias, shifts, applies ReLU/clip and saturates.
- Presents the POY×POX result block on a valid/ready output register toward the pointwise stage.

Parameters:
- DW, 32, pixel width, signed.
- WW, 16, weight width, signed.
- AW, 64, accumulator and bias width, signed.
- OW, 32, output width, signed.
- POY, 3, output rows per block.
- POX, 16, output columns per block.
- KSIZE, 3, kernel edge; taps per window = KSIZE*KSIZE.
- SHIFT, 16, arithmetic right shift applied after the bias add.
- RELU, 1, 1 clamps negative results to 0.
- CLIP, 0, nonzero is the upper clamp (ReLU6 scaling); 0 means saturate at OW max only.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dwpe_ena  in  1  pixel slice valid; one tap per high cycle.
- blkend  in  1  block end; discards any partial window.
- dwpixel_array  in  [POY][POX]×DW  pixel slice for the current tap.
- w_we  in  1  weight write strobe.
- w_addr  in  $clog2(KSIZE*KSIZE)  tap index to write.
- w_data  in  WW  weight value.
- b_we  in  1  bias write strobe.
- b_data  in  AW  bias value.
- out_ready  in  1  consumer ready.
- out_valid  out  1  result block valid.
- out_data  out  [POY][POX]×OW  result block.
- tap_busy  out  1  tap counter nonzero (window in progress).
- ovf  out  1  sticky: a result was dropped.
- werr  out  1  one-cycle pulse: a weight or bias write was rejected.

Behaviour:
- Reset (rst=1 at a clk edge): tap counter, accumulators, pipeline valids, out_valid, out_data, ovf, werr and tap_busy all go to 0. Weight and bias registers also go to 0.
- Tap counter tc (0..KSIZE*KSIZE-1):
  - Increments on each edge where dwpe_ena=1.
  - Wraps to 0 after the final tap.
  - Holds when dwpe_ena=0, so gaps between taps are legal.
- Stage 1 (edge E sampling dwpe_ena): register prod[y][x] = dwpixel_array[y][x]*weight[tc], sign-extended to AW, together with first/last tap flags.
- Stage 2 (edge E+1): on the first tap, acc = prod; on other taps, acc = acc + prod. Wrap in AW is not checked.
- Stage 3 (edge E+2, last tap only):
  - r = (acc+bias) >>> SHIFT.
  - If RELU=1 and r<0, r = 0.
  - If CLIP≠0 and r>CLIP, r = CLIP.
  - Saturate r to the signed OW range.
  - Load out_data and set out_valid.
- Latency: out_valid rises in the cycle after edge E+2, where E is the edge that sampled the final tap. Throughput is one tap per cycle; back-to-back windows need no bubble.
- Output handshake:
  - out_valid stays high and out_data stays stable until an edge with out_ready=1.
  - Same-edge accept and new load: the new result loads and out_valid stays 1.
  - New result while out_valid=1 and out_ready=0: the new result is dropped, the held result is kept, and ovf is set. ovf clears only on rst.
- blkend=1 at an edge:
  - tc goes to 0 and in-flight non-final partial sums are discarded.
  - If the same edge samples dwpe_ena=1 on the final tap, that window completes normally.
  - If the edge samples a non-final tap, that tap is discarded too.
  - A result already in stages 2–3 for a completed window is unaffected.
- Weight/bias writes:
  - Accepted only when tc=0 and no window is in flight in stage 1 or 2; they take effect for taps sampled from the next edge on.
  - Otherwise the write is ignored and werr pulses for one cycle.
  - w_we and b_we together are both applied when accepted.
  - w_addr ≥ KSIZE*KSIZE: ignored and werr pulses.
- tap_busy = (tc≠0).
- rst asserted mid-window or mid-handshake: everything clears per reset; no output is produced for the aborted window.

Test Plan:
1. Reset: hold rst 3 cycles with dwpe_ena toggling -> out_valid=0, out_data all 0, ovf=0, tap_busy=0 throughout.
2. Basic window: SHIFT=0, all 9 weights =1, bias=0; 9 consecutive ena cycles, all pixels =2 -> out_data all 18; out_valid rises 2 cycles after the final-tap edge; held until out_ready=1.
3. Gapped taps plus bias: weights 1..9, pixel =1, bias=100, 2 idle cycles between taps, SHIFT=0 -> out_data all 145; tap_busy high from tap 1 through tap 8.
4. blkend abort: 4 taps, then blkend -> no out_valid; the next 9 taps with pixel=3, weights=1 -> out_data all 27.
5. Clamping: weights all -1, pixel=5, RELU=1 -> 0. Then RELU=0 -> -45. Then CLIP=6 (RELU=1, positive weights, pixel=5) -> 6.
6. Backpressure and write error: out_ready=0 and two windows complete -> first result retained, ovf=1. w_we issued at tc=3 -> werr pulses 1 cycle and the weight is unchanged on the next window.
